// File: rtl/prescaled_gray_counter_pkg.sv
// Shared definitions for the prescaled Gray counter: mode encodings and the
// binary-to-Gray conversion used wherever a Gray value is formed.
package prescaled_gray_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Callers zero-extend into 32 bits and truncate the result back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/prescaled_gray_counter_if.sv
// Control and status bundle of the prescaled Gray counter; the master drives
// controls and observes the count, the slave is the counter itself.
interface prescaled_gray_counter_if
  import prescaled_gray_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 26
);

  logic             en;
  logic             dir;
  mode_e            mode;
  logic [DIV_W-1:0] div;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             tick;
  logic             tc;
  logic             cur_dir;

  modport master (
    output en, dir, mode, div, load, load_val,
    input  gray, bin, tick, tc, cur_dir
  );

  modport slave (
    input  en, dir, mode, div, load, load_val,
    output gray, bin, tick, tc, cur_dir
  );

endinterface

// File: rtl/prescaled_gray_counter_tick_divider.sv
// Prescaler: tick is the "step fires on this edge" strobe, asserted while
// enabled once presc has reached div; presc restarts from zero on that edge.
module tick_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] presc;

  // The >= compare lets a shrinking div fire at once instead of wrapping presc.
  assign tick = en && !reset && (presc >= div);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + ONE;
    end
  end

endmodule

// File: rtl/prescaled_gray_counter.sv
// Up/down/saturating/bounce counter stepping once per prescaler interval,
// publishing registered binary and Gray views of the same count.
module prescaled_gray_counter
  import prescaled_gray_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 26
) (
  input logic                    clk,
  input logic                    reset,
  prescaled_gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             step;
  logic             up;
  logic [WIDTH-1:0] bin_q, bin_d, gray_q;
  logic             dir_q, dir_d;
  logic             tick_q, tc_q, tc_d;

  // Load restarts the prescaler interval exactly like reset does.
  tick_divider #(.DIV_W(DIV_W)) u_tick_divider (
    .clk   (clk),
    .reset (reset || bus.load),
    .en    (bus.en),
    .div   (bus.div),
    .tick  (step)
  );

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    bin_d = bin_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    up    = (bus.mode == MODE_BOUNCE) ? dir_q : bus.dir;
    if (bus.load) begin
      bin_d = bus.load_val;
    end else if (step) begin
      case (bus.mode)
        MODE_SAT: begin
          if (up ? (bin_q == MAX) : (bin_q == '0)) tc_d = 1'b1;
          else bin_d = up ? bin_q + ONE : bin_q - ONE;
        end
        MODE_BOUNCE: begin
          if (up && bin_q == MAX) begin
            bin_d = MAX - ONE;
            dir_d = 1'b0;
            tc_d  = 1'b1;
          end else if (!up && bin_q == '0) begin
            bin_d = ONE;
            dir_d = 1'b1;
            tc_d  = 1'b1;
          end else begin
            bin_d = up ? bin_q + ONE : bin_q - ONE;
          end
        end
        default: begin
          bin_d = up ? bin_q + ONE : bin_q - ONE;
          tc_d  = up ? (bin_q == MAX) : (bin_q == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      dir_q  <= 1'b1;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= WIDTH'(bin2gray(32'(bin_d)));
      dir_q  <= dir_d;
      tick_q <= step;
      tc_q   <= tc_d;
    end
  end

  assign bus.bin     = bin_q;
  assign bus.gray    = gray_q;
  assign bus.tick    = tick_q;
  assign bus.tc      = tc_q;
  assign bus.cur_dir = up;

endmodule

// File: tb/tb_prescaled_gray_counter.sv
// Directed and randomized checks of prescaled_gray_counter at widths 4, 3 and 8;
// the 8-bit instance is compared every edge against a behavioural model.
module tb_prescaled_gray_counter;
  import prescaled_gray_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst3, rst8;

  prescaled_gray_counter_if #(.WIDTH(4)) b4 ();
  prescaled_gray_counter_if #(.WIDTH(3)) b3 ();
  prescaled_gray_counter_if #(.WIDTH(8)) b8 ();

  prescaled_gray_counter #(.WIDTH(4)) u4 (.clk(clk), .reset(rst4), .bus(b4));
  prescaled_gray_counter #(.WIDTH(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));
  prescaled_gray_counter #(.WIDTH(8)) u8 (.clk(clk), .reset(rst8), .bus(b8));

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] g4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Reference state for the 8-bit instance.
  int m_bin, m_el;
  bit m_dirq, m_tick, m_tc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge8();
    bit up;
    int nb;
    up = (b8.mode == MODE_BOUNCE) ? m_dirq : b8.dir;
    m_tick = 1'b0;
    m_tc   = 1'b0;
    if (rst8) begin
      m_bin = 0; m_el = 0; m_dirq = 1'b1;
    end else if (b8.load) begin
      m_bin = int'(b8.load_val); m_el = 0;
    end else if (b8.en) begin
      if (m_el >= int'(b8.div)) begin
        m_el   = 0;
        m_tick = 1'b1;
        if (b8.mode == MODE_SAT) begin
          if (up ? m_bin == 255 : m_bin == 0) m_tc = 1'b1;
          else m_bin = up ? m_bin + 1 : m_bin - 1;
        end else if (b8.mode == MODE_BOUNCE) begin
          if (up && m_bin == 255) begin
            m_bin = 254; m_dirq = 1'b0; m_tc = 1'b1;
          end else if (!up && m_bin == 0) begin
            m_bin = 1; m_dirq = 1'b1; m_tc = 1'b1;
          end else begin
            m_bin = up ? m_bin + 1 : m_bin - 1;
          end
        end else begin
          nb   = up ? m_bin + 1 : m_bin - 1;
          m_tc = (nb > 255) || (nb < 0);
          m_bin = (nb + 256) % 256;
        end
      end else begin
        m_el++;
      end
    end
  endtask

  // Advance one clock, then compare the 8-bit instance against the model.
  task automatic edge_chk();
    bit exp_dir;
    model_edge8();
    @(posedge clk);
    #1;
    exp_dir = (b8.mode == MODE_BOUNCE) ? m_dirq : b8.dir;
    check("u8.bin",     32'(b8.bin),     32'(m_bin));
    check("u8.gray",    32'(b8.gray),    32'(m_bin ^ (m_bin >> 1)));
    check("u8.tick",    32'(b8.tick),    32'(m_tick));
    check("u8.tc",      32'(b8.tc),      32'(m_tc));
    check("u8.cur_dir", 32'(b8.cur_dir), 32'(exp_dir));
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1; rst8 = 1'b1;
    b4.en = 1'b0; b4.dir = 1'b1; b4.mode = MODE_WRAP; b4.div = '0; b4.load = 1'b0; b4.load_val = '0;
    b3.en = 1'b0; b3.dir = 1'b1; b3.mode = MODE_WRAP; b3.div = '0; b3.load = 1'b0; b3.load_val = '0;
    b8.en = 1'b0; b8.dir = 1'b1; b8.mode = MODE_WRAP; b8.div = '0; b8.load = 1'b0; b8.load_val = '0;
    edge_chk();

    check("rst.bin",     32'(b4.bin),     32'(0));
    check("rst.gray",    32'(b4.gray),    32'(0));
    check("rst.tick",    32'(b4.tick),    32'(0));
    check("rst.tc",      32'(b4.tc),      32'(0));
    check("rst.cur_dir", 32'(b4.cur_dir), 32'(1));

    // 4-bit wrap, one step per cycle: full Gray cycle, tc only on 15->0.
    rst4 = 1'b0; rst8 = 1'b0;
    b4.en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      edge_chk();
      check("wrap.gray", 32'(b4.gray), 32'(g4[i % 16]));
      check("wrap.tc",   32'(b4.tc),   32'(i == 16));
    end

    // div=3: tick every 4th cycle, then a 5-cycle enable gap mid-interval.
    b4.div = 3;
    for (int i = 1; i <= 13; i++) begin
      edge_chk();
      check("div3.tick", 32'(b4.tick), 32'(i % 4 == 0));
      check("div3.bin",  32'(b4.bin),  32'(i / 4));
    end
    b4.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_chk();
      check("hold.tick", 32'(b4.tick), 32'(0));
      check("hold.bin",  32'(b4.bin),  32'(3));
    end
    b4.en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      edge_chk();
      check("resume.tick", 32'(b4.tick), 32'(j == 3));
      check("resume.bin",  32'(b4.bin),  32'((j == 3) ? 4 : 3));
    end

    // Saturate at both endpoints.
    b4.div = 0; b4.load = 1'b1; b4.load_val = 4'h0;
    edge_chk();
    check("sat.load0", 32'(b4.bin), 32'(0));
    b4.load = 1'b0; b4.mode = MODE_SAT; b4.dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_chk();
      check("sat.lo.bin", 32'(b4.bin), 32'(0));
      check("sat.lo.tc",  32'(b4.tc),  32'(1));
    end
    b4.dir = 1'b1;
    edge_chk();
    check("sat.up.bin", 32'(b4.bin), 32'(1));
    check("sat.up.tc",  32'(b4.tc),  32'(0));
    b4.load = 1'b1; b4.load_val = 4'hF;
    edge_chk();
    b4.load = 1'b0;
    edge_chk();
    check("sat.hi.bin", 32'(b4.bin), 32'(15));
    check("sat.hi.tc",  32'(b4.tc),  32'(1));
    b4.en = 1'b0;

    // 3-bit bounce; dir input is ignored.
    b3.mode = MODE_BOUNCE; b3.dir = 1'b0; b3.en = 1'b1; rst3 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      int e;
      e = (i <= 7) ? i : ((i <= 14) ? 14 - i : i - 14);
      edge_chk();
      check("bnc.bin",     32'(b3.bin),     32'(e));
      check("bnc.gray",    32'(b3.gray),    32'(e ^ (e >> 1)));
      check("bnc.cur_dir", 32'(b3.cur_dir), 32'((i < 8) || (i == 15)));
      check("bnc.tc",      32'(b3.tc),      32'((i == 8) || (i == 15)));
    end
    b3.en = 1'b0;

    // 8-bit load landing on the edge a step would have fired.
    b8.mode = MODE_WRAP; b8.dir = 1'b1; b8.div = 2; b8.en = 1'b1;
    edge_chk();
    edge_chk();
    b8.load = 1'b1; b8.load_val = 8'hA5;
    edge_chk();
    check("ld.bin",  32'(b8.bin),  32'(8'hA5));
    check("ld.gray", 32'(b8.gray), 32'(8'hF7));
    check("ld.tc",   32'(b8.tc),   32'(0));
    check("ld.tick", 32'(b8.tick), 32'(0));
    b8.load = 1'b0;
    edge_chk();
    edge_chk();
    check("ld.nostep", 32'(b8.bin), 32'(8'hA5));
    edge_chk();
    check("ld.step", 32'(b8.bin), 32'(8'hA6));

    // Reverse the bounce direction, then reset mid-count with load asserted.
    b8.mode = MODE_BOUNCE; b8.div = 0; b8.load = 1'b1; b8.load_val = 8'hFF;
    edge_chk();
    b8.load = 1'b0;
    edge_chk();
    check("rev.bin",     32'(b8.bin),     32'(8'hFE));
    check("rev.cur_dir", 32'(b8.cur_dir), 32'(0));
    b8.div = 2; b8.load = 1'b1; b8.load_val = 8'h3C;
    edge_chk();
    b8.load = 1'b0;
    edge_chk();
    check("mid.bin", 32'(b8.bin), 32'(8'h3C));
    rst8 = 1'b1; b8.load = 1'b1; b8.load_val = 8'h77;
    edge_chk();
    check("rstmid.bin",     32'(b8.bin),     32'(0));
    check("rstmid.gray",    32'(b8.gray),    32'(0));
    check("rstmid.tick",    32'(b8.tick),    32'(0));
    check("rstmid.tc",      32'(b8.tc),      32'(0));
    check("rstmid.cur_dir", 32'(b8.cur_dir), 32'(1));
    rst8 = 1'b0; b8.load = 1'b0;
    edge_chk();
    edge_chk();
    check("rstmid.wait", 32'(b8.bin), 32'(0));
    edge_chk();
    check("rstmid.first", 32'(b8.bin), 32'(1));

    // Randomized traffic on the 8-bit instance, biased toward endpoints.
    for (int i = 0; i < 600; i++) begin
      int pick;
      rst8    = ($urandom_range(0, 99) == 0);
      b8.load = ($urandom_range(0, 24) == 0);
      pick    = int'($urandom_range(0, 4));
      b8.load_val = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h01 :
                    (pick == 2) ? 8'hFE : (pick == 3) ? 8'hFF : 8'($urandom);
      b8.en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) b8.dir = 1'($urandom);
      if ($urandom_range(0, 15) == 0) b8.mode = mode_e'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) b8.div = 26'($urandom_range(0, 3));
      edge_chk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prescaled_gray_counter.md
PRESCALED_GRAY_COUNTER -- requirements
Module: prescaled_gray_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter DIV_W, default 26: prescaler divisor width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; also gates the prescaler.
REQ-006 dir  input  1  1 = count up, 0 = count down; ignored in bounce mode.
REQ-007 mode  input  2  00 wrap, 01 saturate, 10 bounce, 11 treated as wrap.
REQ-008 div  input  DIV_W  step period minus one, in clk cycles.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  binary value applied on load.
REQ-011 gray  output  WIDTH  registered Gray-coded count.
REQ-012 bin  output  WIDTH  registered binary count.
REQ-013 tick  output  1  one-cycle prescaler strobe.
REQ-014 tc  output  1  one-cycle terminal-count pulse.
REQ-015 cur_dir  output  1  effective count direction (1 = up).

Function
REQ-016 The prescaler SHALL be a DIV_W-bit counter presc that increments each cycle en=1 and holds when en=0.
REQ-017 When en=1 and presc >= div, tick SHALL be 1 in the next cycle and presc SHALL return to 0; div=0 gives a tick every enabled cycle.
REQ-018 A step SHALL occur on the edge where tick is computed as 1 (same edge presc returns to 0); bin and gray update on that edge.
REQ-019 Step period SHALL be div+1 cycles; changing div mid-count SHALL take effect immediately via the >= compare, with no lockup.
REQ-020 gray SHALL always equal bin XOR (bin >> 1), both registered on the same edge (zero relative latency).
REQ-021 Wrap mode: bin SHALL step +1/-1 modulo 2^WIDTH per dir; cur_dir SHALL follow dir.
REQ-022 Saturate mode: a step beyond MAX (2^WIDTH-1) up or beyond 0 down SHALL leave bin unchanged.
REQ-023 Bounce mode: an internal direction register SHALL drive cur_dir; stepping up at MAX SHALL yield MAX-1 and set cur_dir=0; stepping down at 0 SHALL yield 1 and set cur_dir=1.
REQ-024 tc SHALL pulse for one cycle, coincident with the bin update, on: the wrapping step (wrap), every step attempted at an endpoint (saturate), every reversal step (bounce).
REQ-025 load=1 SHALL set bin=load_val, gray accordingly, presc=0, tick=0, tc=0 on the next edge, overriding any coincident step, regardless of en.
REQ-026 Entering bounce mode SHALL continue from current bin, with the direction register unchanged since its last write.
REQ-027 Mode changes while counting SHALL apply on the next step; no extra step or tc SHALL result.

Reset
REQ-028 reset=1 SHALL, on the next clk edge, force bin=0, gray=0, presc=0, tick=0, tc=0, direction register=1; reset SHALL take priority over load and step.
REQ-029 Reset mid-count SHALL discard any in-progress prescaler interval; counting SHALL resume from 0 with a full div+1 interval.

Structure
REQ-030 A shared package SHALL hold mode encodings (MODE_WRAP, MODE_SAT, MODE_BOUNCE) and a bin-to-Gray function.
REQ-031 The prescaler SHALL be a separate sub-module tick_divider (clk, reset, en, div, tick).

Verification
REQ-032 WIDTH=4, wrap, dir=1, div=0, en=1 -> gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; tc high only with the step 15->0.
REQ-033 div=3, en=1 -> tick every 4th cycle, width 1; en=0 for 5 cycles -> presc and bin hold, no tick.
REQ-034 Saturate, dir=0, bin=0, div=0 -> bin stays 0, tc high every cycle; dir=1 -> bin 1, tc low.
REQ-035 WIDTH=3, bounce, div=0 -> bin 0..7,6..0,1; cur_dir falls on 7->6, rises on 0->1; tc on both.
REQ-036 WIDTH=8, load=1, load_val=0xA5 on a tick edge -> bin=0xA5, gray=0xF7, presc=0, tc=0, no step.
REQ-037 reset asserted mid-count at bin=0x3C with load=1 -> next edge all outputs 0, cur_dir=1; first step after div+1 cycles.
